// File: rtl/stopwatch_run_control.sv
// Stopwatch run control: button synchronise/debounce, run FSM, 1 s prescaler,
// cascaded BCD MM:SS counters and the registered display/lap path.
// Optional feature macro: STOPWATCH_AUTO_STOP_EN (stop at 59:59 instead of wrapping).
module stopwatch_run_control #(
    parameter int unsigned TICK_DIV        = 5_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    output logic [15:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        sec_tick,
    output logic        wrap
);

    localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PsW = $clog2(TICK_DIV);
    localparam logic [DbW-1:0] DbCntMax = DbW'(DEBOUNCE_CYCLES);
    localparam logic [PsW-1:0] PsLast   = PsW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StStop, StLap} state_e;

    // Bit 0 is start/stop, bit 1 is lap.
    logic [1:0]          btn_raw;
    logic [1:0]          sync1_q, sync2_q;
    logic [1:0]          cand_q, cand_d;
    logic [1:0]          level_q, level_d;
    logic [1:0]          level_dly_q;
    logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          press;
    logic                ss_press, lp_press;

    state_e         state_q, state_d;
    logic [PsW-1:0] presc_q, presc_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    lap_q, lap_d;
    logic [15:0]    disp_q, disp_d;
    logic           freeze_q, freeze_d;
    logic           tick_q, wrap_q, wrap_d;
    logic           run_st, tick_term, at_max, clear;
`ifdef STOPWATCH_AUTO_STOP_EN
    logic           auto_q, auto_d;
`endif

    assign btn_raw  = {btn_lap, btn_start_stop};
    assign press    = level_q & ~level_dly_q;
    assign ss_press = press[0];
    assign lp_press = press[1];

    // Debounce: a sampled level must stay unchanged for DEBOUNCE_CYCLES samples to be accepted.
    always_comb begin
        cand_d   = cand_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != cand_q[i]) begin
                cand_d[i]   = sync2_q[i];
                db_cnt_d[i] = DbW'(1);
            end else if (db_cnt_q[i] < DbCntMax) begin
                db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
            if (db_cnt_d[i] >= DbCntMax) begin
                level_d[i] = cand_d[i];
            end
        end
    end

    assign run_st    = (state_q == StRun) || (state_q == StLap);
    assign tick_term = run_st && (presc_q == PsLast);
    assign at_max    = (cnt_q == 16'h5959);

    // Run FSM, prescaler, BCD counter cascade, lap capture and display select.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        lap_d    = lap_q;
        freeze_d = freeze_q;
        wrap_d   = 1'b0;
        clear    = 1'b0;
`ifdef STOPWATCH_AUTO_STOP_EN
        auto_d   = auto_q;
`endif

        // Start/stop wins over lap when both arrive together.
        case (state_q)
            StIdle: begin
                if (ss_press) state_d = StRun;
            end
            StRun: begin
                if (ss_press) begin
                    state_d = StStop;
                end else if (lp_press) begin
                    state_d  = StLap;
                    lap_d    = cnt_q;
                    freeze_d = 1'b1;
                end
            end
            StLap: begin
                if (ss_press) begin
                    state_d = StStop;
                end else if (lp_press) begin
                    state_d  = StRun;
                    freeze_d = 1'b0;
                end
            end
            StStop: begin
                if (ss_press) begin
`ifdef STOPWATCH_AUTO_STOP_EN
                    if (!auto_q) state_d = StRun;
`else
                    state_d = StRun;
`endif
                end else if (lp_press) begin
                    state_d  = StIdle;
                    freeze_d = 1'b0;
                    clear    = 1'b1;
`ifdef STOPWATCH_AUTO_STOP_EN
                    auto_d   = 1'b0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Prescaler holds in STOP so the sub-second fraction survives a pause.
        if (clear || (state_q == StIdle)) begin
            presc_d = '0;
        end else if (run_st) begin
            presc_d = tick_term ? '0 : presc_q + PsW'(1);
        end

        if (clear) begin
            cnt_d = '0;
        end else if (tick_term) begin
            if (at_max) begin
                wrap_d = 1'b1;
`ifdef STOPWATCH_AUTO_STOP_EN
                state_d = StStop;
                presc_d = '0;
                auto_d  = 1'b1;
`else
                cnt_d = '0;
`endif
            end else if (cnt_q[3:0] != 4'd9) begin
                cnt_d[3:0] = cnt_q[3:0] + 4'd1;
            end else begin
                cnt_d[3:0] = 4'd0;
                if (cnt_q[7:4] != 4'd5) begin
                    cnt_d[7:4] = cnt_q[7:4] + 4'd1;
                end else begin
                    cnt_d[7:4] = 4'd0;
                    if (cnt_q[11:8] != 4'd9) begin
                        cnt_d[11:8] = cnt_q[11:8] + 4'd1;
                    end else begin
                        cnt_d[11:8]  = 4'd0;
                        cnt_d[15:12] = cnt_q[15:12] + 4'd1;
                    end
                end
            end
        end

        if (clear) begin
            disp_d = '0;
        end else begin
            disp_d = freeze_d ? lap_d : cnt_q;
        end
    end

    // All state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            db_cnt_q    <= '0;
            state_q     <= StIdle;
            presc_q     <= '0;
            cnt_q       <= '0;
            lap_q       <= '0;
            disp_q      <= '0;
            freeze_q    <= 1'b0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef STOPWATCH_AUTO_STOP_EN
            auto_q      <= 1'b0;
`endif
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            lap_q       <= lap_d;
            disp_q      <= disp_d;
            freeze_q    <= freeze_d;
            tick_q      <= tick_term;
            wrap_q      <= wrap_d;
`ifdef STOPWATCH_AUTO_STOP_EN
            auto_q      <= auto_d;
`endif
        end
    end

    assign disp_bcd   = disp_q;
    assign running    = run_st;
    assign lap_active = (state_q == StLap);
    assign sec_tick   = tick_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_stopwatch_run_control.sv
// Directed bench for stopwatch_run_control with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Honours STOPWATCH_AUTO_STOP_EN for the 59:59 behaviour.
module tb_stopwatch_run_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lp = 1'b0;
    logic [15:0] disp_bcd;
    logic        running, lap_active, sec_tick, wrap;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;

    stopwatch_run_control #(
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (btn_ss),
        .btn_lap        (btn_lp),
        .disp_bcd       (disp_bcd),
        .running        (running),
        .lap_active     (lap_active),
        .sec_tick       (sec_tick),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int sec;
        m   = (s % 3600) / 60;
        sec = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    // One cycle; outputs sampled on the falling edge, ticks/wraps tallied.
    task automatic step();
        @(negedge clk);
        if (sec_tick) tick_cnt++;
        if (wrap) wrap_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold the chosen buttons long enough to debounce, then release long enough to settle.
    task automatic press(input logic do_ss, input logic do_lp);
        btn_ss = do_ss;
        btn_lp = do_lp;
        steps(10);
        btn_ss = 1'b0;
        btn_lp = 1'b0;
        steps(10);
    endtask

    task automatic wait_tick(output int waited);
        waited = 0;
        do begin
            step();
            waited++;
        end while (!sec_tick && waited < 16);
        check_eq("tick_seen", 32'(sec_tick), 32'd1);
    endtask

    task automatic check_live(input string tag);
        int w;
        wait_tick(w);
        step();
        check_eq(tag, 32'(disp_bcd), 32'(to_bcd(tick_cnt)));
    endtask

    initial begin
        int w;
        int n;
        int t0;
        int guard;
        logic [15:0] lap_exp;
        logic [15:0] stop_exp;

        // Reset values
        steps(2);
        check_eq("rst_disp", 32'(disp_bcd), 32'h0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_lap", 32'(lap_active), 32'd0);
        check_eq("rst_tick", 32'(sec_tick), 32'd0);
        check_eq("rst_wrap", 32'(wrap), 32'd0);
        reset = 1'b0;
        steps(2);

        // Two-cycle glitch must not be accepted
        btn_ss = 1'b1;
        steps(2);
        btn_ss = 1'b0;
        steps(20);
        check_eq("glitch_running", 32'(running), 32'd0);
        check_eq("glitch_disp", 32'(disp_bcd), 32'h0);
        check_eq("glitch_ticks", 32'(tick_cnt), 32'd0);

        // Start and count through a tens carry
        press(1'b1, 1'b0);
        check_eq("start_running", 32'(running), 32'd1);
        check_eq("start_lap", 32'(lap_active), 32'd0);
        for (int i = 0; i < 10; i++) begin
            wait_tick(w);
            if (i > 0) check_eq("tick_period", 32'(w + 1), 32'd4);
            step();
            check_eq("count", 32'(disp_bcd), 32'(to_bcd(tick_cnt)));
        end

        // Lap freezes the display while counting continues
        wait_tick(w);
        lap_exp = to_bcd(tick_cnt + 1);
        press(1'b0, 1'b1);
        check_eq("lap_active", 32'(lap_active), 32'd1);
        check_eq("lap_running", 32'(running), 32'd1);
        check_eq("lap_frozen", 32'(disp_bcd), 32'(lap_exp));
        t0 = tick_cnt;
        steps(12);
        check_eq("lap_ticks_go_on", 32'((tick_cnt - t0) >= 2), 32'd1);
        check_eq("lap_still_frozen", 32'(disp_bcd), 32'(lap_exp));
        press(1'b0, 1'b1);
        check_eq("unlap_active", 32'(lap_active), 32'd0);
        check_eq("unlap_running", 32'(running), 32'd1);
        check_live("unlap_live");

        // Stop holds everything; resume keeps the sub-second fraction
        wait_tick(w);
        stop_exp = to_bcd(tick_cnt + 1);
        press(1'b1, 1'b0);
        check_eq("stop_running", 32'(running), 32'd0);
        check_eq("stop_disp", 32'(disp_bcd), 32'(stop_exp));
        t0 = tick_cnt;
        steps(20);
        check_eq("stop_hold_disp", 32'(disp_bcd), 32'(stop_exp));
        check_eq("stop_no_tick", 32'(tick_cnt), 32'(t0));
        btn_ss = 1'b1;
        w = 0;
        do begin
            step();
            w++;
        end while (!running && w < 15);
        check_eq("resume_running", 32'(running), 32'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (!sec_tick && n < 8);
        check_eq("resume_first_tick", 32'(sec_tick && (n <= 4)), 32'd1);
        btn_ss = 1'b0;
        steps(10);
        check_live("resume_live");

        // Simultaneous presses from RUN: start/stop wins
        press(1'b1, 1'b1);
        check_eq("both_running", 32'(running), 32'd0);
        check_eq("both_lap", 32'(lap_active), 32'd0);
        press(1'b0, 1'b1);
        check_eq("clear_disp", 32'(disp_bcd), 32'h0);
        check_eq("clear_running", 32'(running), 32'd0);
        tick_cnt = 0;
        wrap_cnt = 0;

        // Full hour: 59:59 then the terminal tick
        press(1'b1, 1'b0);
        guard = 0;
        while (tick_cnt < 3600 && guard < 20000) begin
            step();
            guard++;
            if (sec_tick && tick_cnt == 3599) begin
                step();
                check_eq("disp_5959", 32'(disp_bcd), 32'h5959);
            end
        end
        check_eq("hour_reached", 32'(tick_cnt), 32'd3600);
        check_eq("wrap_with_tick", 32'(wrap && sec_tick), 32'd1);
        step();
        check_eq("wrap_one_cycle", 32'(wrap), 32'd0);
        check_eq("wrap_count", 32'(wrap_cnt), 32'd1);
`ifdef STOPWATCH_AUTO_STOP_EN
        step();
        check_eq("auto_disp", 32'(disp_bcd), 32'h5959);
        check_eq("auto_running", 32'(running), 32'd0);
        press(1'b1, 1'b0);
        check_eq("auto_ss_ignored", 32'(running), 32'd0);
        check_eq("auto_hold", 32'(disp_bcd), 32'h5959);
        press(1'b0, 1'b1);
        check_eq("auto_clear", 32'(disp_bcd), 32'h0);
        press(1'b1, 1'b0);
`else
        check_eq("wrap_disp", 32'(disp_bcd), 32'h0000);
        check_eq("wrap_running", 32'(running), 32'd1);
`endif

        // Asynchronous reset from LAP
        press(1'b0, 1'b1);
        check_eq("pre_rst_lap", 32'(lap_active), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("arst_disp", 32'(disp_bcd), 32'h0);
        check_eq("arst_running", 32'(running), 32'd0);
        check_eq("arst_lap", 32'(lap_active), 32'd0);
        check_eq("arst_tick", 32'(sec_tick), 32'd0);
        check_eq("arst_wrap", 32'(wrap), 32'd0);
        steps(2);
        reset = 1'b0;
        steps(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
